// File: rtl/hazard_ctrl_unit.sv
// ID-stage hazard controller: load-use, branch/jr operand and mult/div stalls,
// plus a saturating stall-cycle performance counter.
module hazard_ctrl_unit #(
   parameter int unsigned REG_AW     = 5,
   parameter int unsigned MD_LAT     = 4,
   parameter int unsigned BR_FWD_MEM = 1,
   parameter int unsigned JR_CHECK   = 1,
   parameter int unsigned CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] Rs_ID,
   input  logic [REG_AW-1:0] Rt_ID,
   input  logic              useRs_ID,
   input  logic              useRt_ID,
   input  logic              branch_ID,
   input  logic              jr_ID,
   input  logic              md_use_ID,
   input  logic              memRead_EX,
   input  logic              regWrite_EX,
   input  logic [REG_AW-1:0] wreg_EX,
   input  logic              md_start_EX,
   input  logic              memRead_MEM,
   input  logic              regWrite_MEM,
   input  logic [REG_AW-1:0] wreg_MEM,
   input  logic              cnt_clr,
   output logic              clr_control,
   output logic              IF_ID_write,
   output logic              PC_write,
   output logic              md_busy,
   output logic [2:0]        stall_cause,
   output logic [CNT_W-1:0]  stall_cycles
);

   localparam int unsigned MD_CW  = (MD_LAT == 0) ? 1 : $clog2(MD_LAT + 1);
   localparam logic        BR_FWD = (BR_FWD_MEM != 0);
   localparam logic        JR_EN  = (JR_CHECK != 0);

   logic rs_ex, rt_ex, rs_mem, rt_mem;
   logic mem_hit;
   logic h_ld, h_br, h_md, stall;

   // Register 0 is hardwired zero, so it never creates a dependency.
   always_comb begin
      rs_ex  = useRs_ID && (Rs_ID == wreg_EX)  && (wreg_EX  != '0);
      rt_ex  = useRt_ID && (Rt_ID == wreg_EX)  && (wreg_EX  != '0);
      rs_mem = useRs_ID && (Rs_ID == wreg_MEM) && (wreg_MEM != '0);
      rt_mem = useRt_ID && (Rt_ID == wreg_MEM) && (wreg_MEM != '0);
   end

   // With MEM forwarding into the ID compare, only a load in MEM is still unresolved.
   assign mem_hit = regWrite_MEM & (memRead_MEM | ~BR_FWD);

   always_comb begin
      h_ld = memRead_EX & (rs_ex | rt_ex);
      h_br = (branch_ID & ((regWrite_EX & (rs_ex | rt_ex)) | (mem_hit & (rs_mem | rt_mem))))
           | (JR_EN & jr_ID & ((regWrite_EX & rs_ex) | (mem_hit & rs_mem)));
      h_md = md_busy & md_use_ID;
      stall = h_ld | h_br | h_md;
   end

   assign clr_control = stall;
   assign IF_ID_write = ~stall;
   assign PC_write    = ~stall;
   assign stall_cause = {h_md, h_br, h_ld};

   // Mult/div latency tracker; a start while busy reloads the full latency.
   generate
      if (MD_LAT == 0) begin : g_no_md
         logic unused_md_start;
         assign unused_md_start = md_start_EX;
         assign md_busy = 1'b0;
      end else begin : g_md
         logic [MD_CW-1:0] md_cnt;
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               md_cnt <= '0;
            end else if (md_start_EX) begin
               md_cnt <= MD_CW'(MD_LAT);
            end else if (md_cnt != '0) begin
               md_cnt <= md_cnt - MD_CW'(1);
            end
         end
         assign md_busy = (md_cnt != '0);
      end
   endgenerate

   // Saturating stall counter; clear wins over a same-cycle stall.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles <= '0;
      end else if (cnt_clr) begin
         stall_cycles <= '0;
      end else if (stall && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: default instance plus an alternate
// (MD_LAT=0, BR_FWD_MEM=0, JR_CHECK=0, CNT_W=4) driven from the same inputs.
module tb_hazard_ctrl_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] Rs_ID, Rt_ID, wreg_EX, wreg_MEM;
   logic       useRs_ID, useRt_ID, branch_ID, jr_ID, md_use_ID;
   logic       memRead_EX, regWrite_EX, md_start_EX;
   logic       memRead_MEM, regWrite_MEM, cnt_clr;

   logic        clr0, ifid0, pc0, busy0;
   logic [2:0]  cause0;
   logic [15:0] cnt0;
   logic        clr1, ifid1, pc1, busy1;
   logic [2:0]  cause1;
   logic [3:0]  cnt1;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } sb_t;
   sb_t sb[$];

   int unsigned npass  = 0;
   int unsigned ntotal = 0;
   int unsigned step   = 0;

   // bench-side models of the registered state
   int unsigned m_cnt0 = 0, m_cnt1 = 0, m_md = 0;

   always #5 clk = ~clk;

   hazard_ctrl_unit u0 (
      .clk(clk), .rst(rst), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
      .useRs_ID(useRs_ID), .useRt_ID(useRt_ID), .branch_ID(branch_ID),
      .jr_ID(jr_ID), .md_use_ID(md_use_ID), .memRead_EX(memRead_EX),
      .regWrite_EX(regWrite_EX), .wreg_EX(wreg_EX), .md_start_EX(md_start_EX),
      .memRead_MEM(memRead_MEM), .regWrite_MEM(regWrite_MEM), .wreg_MEM(wreg_MEM),
      .cnt_clr(cnt_clr), .clr_control(clr0), .IF_ID_write(ifid0), .PC_write(pc0),
      .md_busy(busy0), .stall_cause(cause0), .stall_cycles(cnt0)
   );

   hazard_ctrl_unit #(.MD_LAT(0), .BR_FWD_MEM(0), .JR_CHECK(0), .CNT_W(4)) u1 (
      .clk(clk), .rst(rst), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
      .useRs_ID(useRs_ID), .useRt_ID(useRt_ID), .branch_ID(branch_ID),
      .jr_ID(jr_ID), .md_use_ID(md_use_ID), .memRead_EX(memRead_EX),
      .regWrite_EX(regWrite_EX), .wreg_EX(wreg_EX), .md_start_EX(md_start_EX),
      .memRead_MEM(memRead_MEM), .regWrite_MEM(regWrite_MEM), .wreg_MEM(wreg_MEM),
      .cnt_clr(cnt_clr), .clr_control(clr1), .IF_ID_write(ifid1), .PC_write(pc1),
      .md_busy(busy1), .stall_cause(cause1), .stall_cycles(cnt1)
   );

   function automatic void push(input string tag, input logic [31:0] exp);
      sb_t e;
      e.tag = $sformatf("s%0d_%s", step, tag);
      e.exp = exp;
      sb.push_back(e);
   endfunction

   task automatic check(input logic [31:0] obs);
      sb_t e;
      e = sb.pop_front();
      ntotal++;
      assert (obs === e.exp) npass++;
      else $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
   endtask

   task automatic clear_inputs();
      Rs_ID = '0; Rt_ID = '0; wreg_EX = '0; wreg_MEM = '0;
      useRs_ID = 0; useRt_ID = 0; branch_ID = 0; jr_ID = 0; md_use_ID = 0;
      memRead_EX = 0; regWrite_EX = 0; md_start_EX = 0;
      memRead_MEM = 0; regWrite_MEM = 0; cnt_clr = 0;
   endtask

   // Called just after a negedge with inputs driven: checks the combinational
   // outputs, then advances one posedge and checks the registered state.
   task automatic cyc(input logic [2:0] c0, input logic [2:0] c1);
      step++;
      #1;
      push("cause0", 32'(c0));         check(32'(cause0));
      push("cause1", 32'(c1));         check(32'(cause1));
      push("clr0",   32'(|c0));        check(32'(clr0));
      push("ifid0",  32'(~|c0));       check(32'(ifid0));
      push("pc0",    32'(~|c0));       check(32'(pc0));
      push("pc1",    32'(~|c1));       check(32'(pc1));
      @(posedge clk);
      if (cnt_clr) begin
         m_cnt0 = 0; m_cnt1 = 0;
      end else begin
         if (|c0 && m_cnt0 < 65535) m_cnt0++;
         if (|c1 && m_cnt1 < 15) m_cnt1++;
      end
      if (md_start_EX) m_md = 4;
      else if (m_md != 0) m_md--;
      #1;
      push("cnt0",  m_cnt0);              check(32'(cnt0));
      push("cnt1",  m_cnt1);              check(32'(cnt1));
      push("busy0", 32'(m_md != 0));      check(32'(busy0));
      push("busy1", 32'd0);               check(32'(busy1));
      @(negedge clk);
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      rst = 1'b0;
      #1;
      push("rst_clr0",  0);  check(32'(clr0));
      push("rst_ifid0", 1);  check(32'(ifid0));
      push("rst_pc0",   1);  check(32'(pc0));
      push("rst_cause", 0);  check(32'(cause0));
      push("rst_busy",  0);  check(32'(busy0));
      push("rst_cnt0",  0);  check(32'(cnt0));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // load-use and its qualifiers
      memRead_EX = 1; regWrite_EX = 1; wreg_EX = 8; Rs_ID = 8; useRs_ID = 1;
      cyc(3'b001, 3'b001);
      memRead_EX = 1; regWrite_EX = 1; wreg_EX = 8; Rs_ID = 8; useRs_ID = 0;
      cyc(3'b000, 3'b000);
      memRead_EX = 1; regWrite_EX = 1; wreg_EX = 0; Rs_ID = 0; useRs_ID = 1;
      cyc(3'b000, 3'b000);

      // load feeding a branch: two stall cycles
      memRead_EX = 1; regWrite_EX = 1; wreg_EX = 9; Rs_ID = 9; useRs_ID = 1; branch_ID = 1;
      cyc(3'b011, 3'b011);
      memRead_MEM = 1; regWrite_MEM = 1; wreg_MEM = 9; Rs_ID = 9; useRs_ID = 1; branch_ID = 1;
      cyc(3'b010, 3'b010);
      Rs_ID = 9; useRs_ID = 1; branch_ID = 1;
      cyc(3'b000, 3'b000);

      // ALU result in MEM: forwarded on u0, stalls on u1
      regWrite_MEM = 1; wreg_MEM = 5; Rs_ID = 5; useRs_ID = 1; branch_ID = 1;
      cyc(3'b000, 3'b010);
      regWrite_MEM = 1; wreg_MEM = 5; Rt_ID = 5; useRt_ID = 1; branch_ID = 1;
      cyc(3'b000, 3'b010);

      // jump-register operand
      jr_ID = 1; Rs_ID = 31; useRs_ID = 1; regWrite_EX = 1; wreg_EX = 31;
      cyc(3'b010, 3'b000);
      jr_ID = 1; Rt_ID = 31; useRt_ID = 1; regWrite_EX = 1; wreg_EX = 31;
      cyc(3'b000, 3'b000);
      jr_ID = 1; Rs_ID = 31; useRs_ID = 1; memRead_MEM = 1; regWrite_MEM = 1; wreg_MEM = 31;
      cyc(3'b010, 3'b000);

      // mult/div: 4 busy cycles, then release
      md_start_EX = 1; md_use_ID = 1;
      cyc(3'b000, 3'b000);
      for (int i = 0; i < 4; i++) begin
         md_use_ID = 1;
         cyc(3'b100, 3'b000);
      end
      md_use_ID = 1;
      cyc(3'b000, 3'b000);

      // restart while busy reloads the latency
      md_start_EX = 1;
      cyc(3'b000, 3'b000);
      md_use_ID = 1; cyc(3'b100, 3'b000);
      md_use_ID = 1; cyc(3'b100, 3'b000);
      md_use_ID = 1; md_start_EX = 1; cyc(3'b100, 3'b000);
      for (int i = 0; i < 4; i++) begin
         md_use_ID = 1;
         cyc(3'b100, 3'b000);
      end
      md_use_ID = 1;
      cyc(3'b000, 3'b000);

      // clear beats a same-cycle stall, then saturate the narrow counter
      cnt_clr = 1; memRead_EX = 1; wreg_EX = 8; Rs_ID = 8; useRs_ID = 1;
      cyc(3'b001, 3'b001);
      for (int i = 0; i < 20; i++) begin
         memRead_EX = 1; wreg_EX = 8; Rs_ID = 8; useRs_ID = 1;
         cyc(3'b001, 3'b001);
      end
      push("sat_cnt1", 15); check(32'(cnt1));
      push("run_cnt0", 20); check(32'(cnt0));

      // asynchronous reset in the middle of a mult/div
      md_start_EX = 1;
      cyc(3'b000, 3'b000);
      md_use_ID = 1;
      #2;
      rst = 1'b0;
      #1;
      push("arst_busy0",  0); check(32'(busy0));
      push("arst_cnt0",   0); check(32'(cnt0));
      push("arst_cnt1",   0); check(32'(cnt1));
      push("arst_cause0", 0); check(32'(cause0));
      push("arst_pc0",    1); check(32'(pc0));
      @(negedge clk);
      rst = 1'b1;
      clear_inputs();
      m_md = 0; m_cnt0 = 0; m_cnt1 = 0;
      cyc(3'b000, 3'b000);

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
